// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor, one 8-bit CLA block per stage.
// Define CLA_PIPE_SAT_EN to saturate signed results in the final stage.
module cla_pipe_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N = WIDTH / 8;

  logic             adv;
  logic [WIDTH-1:0] eb;
  logic             ec;

  assign eb       = sub ? ~b : b;
  assign ec       = sub ? 1'b1 : cin;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  function automatic logic [8:0] cla8(
    input logic [7:0] x,
    input logic [7:0] y,
    input logic       ci
  );
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    logic       t;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = ci;
    for (int i = 1; i <= 8; i++) begin
      t = ci;
      for (int m = 0; m < i; m++) t = t & p[m];
      c[i] = t;
      for (int j = 0; j < i; j++) begin
        t = g[j];
        for (int m = j + 1; m < i; m++) t = t & p[m];
        c[i] = c[i] | t;
      end
    end
    return {c[8], p ^ c[7:0]};
  endfunction

  genvar k;
  generate
    for (k = 0; k < N; k++) begin : stg
      localparam int LW = 8 * k + 8;

      logic          vld_q;
      logic          c_q;
      logic          sa_q;
      logic          sb_q;
      logic [LW-1:0] r_q;

      logic          vld_d;
      logic          ci_d;
      logic          sa_d;
      logic          sb_d;
      logic [7:0]    xa_d;
      logic [7:0]    xb_d;
      logic [LW-1:0] r_d;
      logic [8:0]    s8;

      assign s8 = cla8(xa_d, xb_d, ci_d);

      if (k == 0) begin : src
        assign vld_d = in_valid;
        assign xa_d  = a[7:0];
        assign xb_d  = eb[7:0];
        assign ci_d  = ec;
        assign sa_d  = a[WIDTH-1];
        assign sb_d  = eb[WIDTH-1];
        assign r_d   = s8[7:0];
      end else begin : src
        assign vld_d = stg[k-1].vld_q;
        assign xa_d  = stg[k-1].sk.a_q[7:0];
        assign xb_d  = stg[k-1].sk.b_q[7:0];
        assign ci_d  = stg[k-1].c_q;
        assign sa_d  = stg[k-1].sa_q;
        assign sb_d  = stg[k-1].sb_q;
        assign r_d   = {s8[7:0], stg[k-1].r_q};
      end

      // Result, block carry and sign bits advance together on a global step
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          vld_q <= 1'b0;
          c_q   <= 1'b0;
          sa_q  <= 1'b0;
          sb_q  <= 1'b0;
          r_q   <= '0;
        end else if (adv) begin
          vld_q <= vld_d;
          c_q   <= s8[8];
          sa_q  <= sa_d;
          sb_q  <= sb_d;
          r_q   <= r_d;
        end
      end

      if (k < N - 1) begin : sk
        localparam int SW = WIDTH - LW;
        logic [SW-1:0] a_q;
        logic [SW-1:0] b_q;
        logic [SW-1:0] a_d;
        logic [SW-1:0] b_d;

        if (k == 0) begin : sd
          assign a_d = a[WIDTH-1:8];
          assign b_d = eb[WIDTH-1:8];
        end else begin : sd
          assign a_d = stg[k-1].sk.a_q[SW+7:8];
          assign b_d = stg[k-1].sk.b_q[SW+7:8];
        end

        // Skew registers carry the not-yet-added operand bytes
        always_ff @(posedge clock or posedge reset) begin
          if (reset) begin
            a_q <= '0;
            b_q <= '0;
          end else if (adv) begin
            a_q <= a_d;
            b_q <= b_d;
          end
        end
      end
    end
  endgenerate

  logic [WIDTH-1:0] wrap;
  logic             ovf;
  logic             sa;

  assign sa        = stg[N-1].sa_q;
  assign wrap      = stg[N-1].r_q;
  assign ovf       = (sa == stg[N-1].sb_q) && (wrap[WIDTH-1] != sa);
  assign out_valid = stg[N-1].vld_q;
  assign cout      = stg[N-1].c_q;
  assign overflow  = ovf;

`ifdef CLA_PIPE_SAT_EN
  logic [WIDTH-1:0] sat;
  assign sat = {sa, {(WIDTH-1){!sa}}};
  assign sum = ovf ? sat : wrap;
`else
  assign sum = wrap;
`endif

endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor for the ALU datapath, built from 8-bit CLA blocks with one block evaluated per pipeline stage. Operands enter through a valid/ready handshake. The result emerges WIDTH/8 cycles later with carry-out and signed-overflow flags. It replaces single-cycle ripple of block carries on wide (32/64-bit) datapaths where timing does not close combinationally.

## Interface
- `WIDTH`, 32: operand/result width. Must be a multiple of 8 and at least 8.
- `clock` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high. Clears all pipeline state.
- `in_valid` input 1: the operand set on `a`, `b`, `cin`, `sub` is valid.
- `in_ready` output 1: the block can accept an operand set this cycle.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `cin` input 1: carry-in (add mode only).
- `sub` input 1: 1 selects A − B; 0 selects A + B + cin.
- `out_valid` output 1: `sum`/`cout`/`overflow` are valid.
- `out_ready` input 1: the downstream consumer accepts the result this cycle.
- `sum` output WIDTH: result.
- `cout` output 1: carry out of the MSB (in sub mode, 1 means no borrow).
- `overflow` output 1: two's-complement signed overflow.

## Operation
- N = WIDTH/8 stages. Stage k holds a valid bit plus the following:
  - computed result bits [8k+7:0];
  - the registered carry out of block k;
  - the not-yet-used operand bytes k+1..N−1 (skew registers);
  - the sign bits of a and effective b.
- Effective B is `sub ? ~b : b`. The effective carry-in is `sub ? 1 : cin`. `cin` is ignored when `sub`=1.
- Stage 0 adds byte 0 with the effective carry-in. Stage k adds byte k with the registered carry of stage k−1. The lower result bytes pass through unchanged.
- The final stage drives `sum`, `cout` and `overflow`.
  - `overflow` = (a[MSB] == effB[MSB]) && (sum[MSB] != a[MSB]).
- Arithmetic is modulo 2^WIDTH. `cout` is bit WIDTH of a + effB + effCin.
- Flow control uses a global advance: `adv` = !out_valid || out_ready, and `in_ready` = `adv`.
  - When `adv`=1, every stage loads from its predecessor. Stage 0 loads valid = `in_valid`.
  - When `adv`=0, every stage holds.
  - Bubbles are not compressed.
- An operand set is accepted on a cycle where `in_valid && in_ready`.
- Outputs hold stable while `out_valid && !out_ready`.
- Simultaneous accept and output are allowed in one cycle, giving full throughput of one result per cycle.
- WIDTH=8 degenerates to a single registered stage.

## Timing
- Reset values:
  - all stage valid bits 0, so `out_valid`=0;
  - `sum`=0, `cout`=0, `overflow`=0;
  - `in_ready`=1 (because `out_valid`=0).
- Reset is asynchronous. Asserting it mid-operation discards all in-flight operations immediately. No result is produced for them.
- Latency is N cycles from the accepting edge to `out_valid`=1, assuming no stalls. For WIDTH=32 that is 4 cycles.
- Each stall cycle (`out_valid`=1, `out_ready`=0) adds one cycle to every in-flight operation.
- Throughput is 1 per cycle when `out_ready` is held high.
- Input to register path: one 8-bit CLA plus mux only. There is no combinational path from `a`/`b` to any output.
- `in_ready` depends combinationally on `out_ready`.

## Configuration
- `CLA_PIPE_SAT_EN` defined: the final stage saturates signed results.
  - On `overflow`=1, `sum` is forced to 0x7F..F if a[MSB]=0, and to 0x80..0 if a[MSB]=1.
  - `overflow` still reports 1.
  - `cout` is unaffected.
- `CLA_PIPE_SAT_EN` undefined: `sum` is always the wrapped modulo result. No saturation logic is present.

## Test plan
- WIDTH=32, add: a=0xFFFFFFFF, b=0x00000001, cin=0, out_ready=1 → after 4 cycles: sum=0x00000000, cout=1, overflow=0.
- WIDTH=32, sub: a=5, b=7 → sum=0xFFFFFFFE, cout=0. Then a=7, b=5 → sum=2, cout=1. `cin`=1 is ignored in both.
- Overflow: a=0x7FFFFFFF, b=1, add → overflow=1.
  - Without the macro: sum=0x80000000.
  - With `CLA_PIPE_SAT_EN`: sum=0x7FFFFFFF.
- Back-to-back stream of 100 random operations with out_ready=1 → one result per cycle in order, each matching a+effB+effCin. Then hold out_ready=0 for 5 cycles mid-stream → outputs stable, in_ready=0, no loss or duplication.
- Reset with 3 operations in flight → out_valid=0 and sum/cout/overflow=0 asynchronously. After release, the first new operation appears exactly N cycles after acceptance.
- WIDTH=8 exhaustive: all a, b in 0..255 with cin=1, plus sub=1 → sum and cout match the reference arithmetic after 1 cycle, with 0 failures out of 131072.
